// File: rtl/trig_pkg.sv
// Shared types and constants for the multi-channel trigger controller.
package trig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DELAY = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

endpackage

// File: rtl/trigger_unit_if.sv
// Channel-sample, configuration and memory-handshake bundle of the trigger controller.
interface trigger_unit_if #(
    parameter int CH    = 4,
    parameter int DLY_W = 16
);
    logic [CH-1:0]    data;
    logic [2*CH-1:0]  edge_sel;
    logic             combine_all;
    logic [DLY_W-1:0] trig_delay;
    logic             arm;
    logic             write_finish;
    logic             we;
    logic             armed;
    logic             triggered;
    logic             done;
    logic [CH-1:0]    trig_chan;

    modport slave (
        input  data, edge_sel, combine_all, trig_delay, arm, write_finish,
        output we, armed, triggered, done, trig_chan
    );

    modport master (
        output data, edge_sel, combine_all, trig_delay, arm, write_finish,
        input  we, armed, triggered, done, trig_chan
    );
endinterface

// File: rtl/trigger_unit_edge_qual.sv
// Per-channel edge qualifier: compares the current sample with the previous one
// and reports whether the selected edge type occurred.
module edge_qual
    import trig_pkg::*;
(
    input  logic       data_i,
    input  logic       prev_i,
    input  logic [1:0] mode_i,
    output logic       q_o
);

    logic rise;
    logic fall;

    assign rise = ~prev_i & data_i;
    assign fall = prev_i & ~data_i;

    always_comb begin
        q_o = 1'b0;
        case (mode_i)
            EDGE_RISE: q_o = rise;
            EDGE_FALL: q_o = fall;
            EDGE_BOTH: q_o = rise | fall;
            default:   q_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/trigger_unit.sv
// Multi-channel trigger controller: per-channel edge qualification, any/all
// combination, post-trigger delay and sample-memory write enable generation.
module trigger_unit
    import trig_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DLY_W    = 16,
    parameter bit AUTO_ARM = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    trigger_unit_if.slave  bus
);

    localparam logic [DLY_W-1:0] ONE = DLY_W'(1);

    state_e           state_q, state_d;
    logic [CH-1:0]    prev_q, prev_d;
    logic [CH-1:0]    trig_q, trig_d;
    logic [2*CH-1:0]  sel_q, sel_d;
    logic             all_q, all_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] cnt_q, cnt_d;
    logic [CH-1:0]    q;
    logic [CH-1:0]    en;
    logic             hit;
    logic             we;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        edge_qual u_qual (
            .data_i (bus.data[i]),
            .prev_i (prev_q[i]),
            .mode_i (sel_q[2*i +: 2]),
            .q_o    (q[i])
        );
        assign en[i] = |sel_q[2*i +: 2];
    end

    // With every channel ignored q stays zero, so neither mode can ever hit.
    assign hit = all_q ? ((en != '0) && (q == en)) : (|q);

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        trig_d  = trig_q;
        sel_d   = sel_q;
        all_d   = all_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.arm) begin
                    state_d = ST_PRIME;
                    sel_d   = bus.edge_sel;
                    all_d   = bus.combine_all;
                    dly_d   = bus.trig_delay;
                end
            end
            ST_PRIME: begin
                prev_d  = bus.data;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                prev_d = bus.data;
                if (hit) begin
                    trig_d = q;
                    if (dly_q == '0) begin
                        we      = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        // The trigger cycle counts as the first delay sample so
                        // that the first write lands exactly D samples later.
                        cnt_d   = dly_q - ONE;
                        state_d = (dly_q == ONE) ? ST_WRITE : ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                we = ~bus.write_finish;
                if (bus.write_finish) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AUTO_ARM ? ST_PRIME : ST_IDLE;
            prev_q  <= '0;
            trig_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= AUTO_ARM ? bus.edge_sel : '0;
            all_q   <= AUTO_ARM ? bus.combine_all : 1'b0;
            dly_q   <= AUTO_ARM ? bus.trig_delay : '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            trig_q  <= trig_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            all_q   <= all_d;
            dly_q   <= dly_d;
        end
    end

    assign bus.we        = we;
    assign bus.armed     = (state_q == ST_PRIME) || (state_q == ST_WAIT) || (state_q == ST_DELAY);
    assign bus.triggered = (state_q == ST_DELAY) || (state_q == ST_WRITE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.trig_chan = trig_q;

endmodule

// File: tb/tb_trigger_unit.sv
// Directed testbench for trigger_unit: a manually armed instance and an auto-armed one.
module tb_trigger_unit;

    logic clk = 1'b0;
    logic resetA;
    logic resetB;
    int   checks;
    int   errors;

    always #5 clk = ~clk;

    trigger_unit_if #(.CH(4), .DLY_W(16)) ifA ();
    trigger_unit_if #(.CH(4), .DLY_W(16)) ifB ();

    trigger_unit #(.CH(4), .DLY_W(16), .AUTO_ARM(1'b0)) dutA (
        .clk   (clk),
        .reset (resetA),
        .bus   (ifA)
    );

    trigger_unit #(.CH(4), .DLY_W(16), .AUTO_ARM(1'b1)) dutB (
        .clk   (clk),
        .reset (resetB),
        .bus   (ifB)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] d, input logic a, input logic wf);
        ifA.data         = d;
        ifA.arm          = a;
        ifA.write_finish = wf;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetA = 1'b1;
        resetB = 1'b1;
        ifA.data = '0; ifA.edge_sel = '0; ifA.combine_all = 1'b0;
        ifA.trig_delay = '0; ifA.arm = 1'b0; ifA.write_finish = 1'b0;
        ifB.data = '0; ifB.edge_sel = 8'hFF; ifB.combine_all = 1'b0;
        ifB.trig_delay = '0; ifB.arm = 1'b0; ifB.write_finish = 1'b0;
        nextCycle();
        nextCycle();

        // Reset state of both instances
        checkOutput("rst_we", 32'(ifA.we), 32'd0);
        checkOutput("rst_armed", 32'(ifA.armed), 32'd0);
        checkOutput("rst_triggered", 32'(ifA.triggered), 32'd0);
        checkOutput("rst_done", 32'(ifA.done), 32'd0);
        checkOutput("rst_trig_chan", 32'(ifA.trig_chan), 32'd0);
        checkOutput("rstB_armed", 32'(ifB.armed), 32'd1);
        resetA = 1'b0;

        // Single channel rising edge, no delay
        ifA.edge_sel = 8'h01; ifA.combine_all = 1'b0; ifA.trig_delay = 16'd0;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("t1_idle_we", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t1_prime_armed", 32'(ifA.armed), 32'd1);
        checkOutput("t1_prime_trig", 32'(ifA.triggered), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t1_we_at_trigger", 32'(ifA.we), 32'd1);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        checkOutput("t1_write_we", 32'(ifA.we), 32'd1);
        checkOutput("t1_write_trig", 32'(ifA.triggered), 32'd1);
        checkOutput("t1_trig_chan", 32'(ifA.trig_chan), 32'h1);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t1_arm_ignored_trig", 32'(ifA.triggered), 32'd1);
        checkOutput("t1_arm_ignored_done", 32'(ifA.done), 32'd0);
        checkOutput("t1_arm_ignored_we", 32'(ifA.we), 32'd1);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("t1_finish_we", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t1_done", 32'(ifA.done), 32'd1);
        checkOutput("t1_done_we", 32'(ifA.we), 32'd0);
        checkOutput("t1_done_trig_chan", 32'(ifA.trig_chan), 32'h1);

        // Level already high at PRIME must not trigger
        applyStimulus(4'b0001, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t2_level_no_hit", 32'(ifA.we), 32'd0);
        checkOutput("t2_trig_chan_held", 32'(ifA.trig_chan), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_fall_no_hit", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t2_second_rise", 32'(ifA.we), 32'd1);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("t2_write_state", 32'(ifA.triggered), 32'd1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t2_done", 32'(ifA.done), 32'd1);

        // All-channel combine: ch0 rising and ch2 falling on the same sample
        ifA.edge_sel = 8'h21; ifA.combine_all = 1'b1;
        applyStimulus(4'b0100, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(4'b0100, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3_ch2_alone", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t3_ch0_alone", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0100, 1'b0, 1'b1);
        checkOutput("t3_wrong_edges", 32'(ifA.we), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b1);
        checkOutput("t3_same_cycle_hit", 32'(ifA.we), 32'd1);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t3_finish_ignored_trig", 32'(ifA.triggered), 32'd1);
        checkOutput("t3_finish_ignored_done", 32'(ifA.done), 32'd0);
        checkOutput("t3_trig_chan", 32'(ifA.trig_chan), 32'h5);
        checkOutput("t3_write_we", 32'(ifA.we), 32'd1);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("t3_done", 32'(ifA.done), 32'd1);

        // Delay of 5 samples; inputs changed after arming must be ignored
        ifA.edge_sel = 8'h01; ifA.combine_all = 1'b0; ifA.trig_delay = 16'd5;
        applyStimulus(4'b0000, 1'b1, 1'b0);
        nextCycle();
        ifA.edge_sel = 8'h00; ifA.combine_all = 1'b1; ifA.trig_delay = 16'd0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t4_we_t0", 32'(ifA.we), 32'd0);
        checkOutput("t4_trig_t0", 32'(ifA.triggered), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            applyStimulus(4'b0001, 1'b0, 1'b0);
            checkOutput($sformatf("t4_we_t%0d", k), 32'(ifA.we), 32'd0);
            checkOutput($sformatf("t4_trig_t%0d", k), 32'(ifA.triggered), 32'd1);
        end
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t4_we_t5", 32'(ifA.we), 32'd1);
        checkOutput("t4_armed_t5", 32'(ifA.armed), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t4_we_t6", 32'(ifA.we), 32'd1);

        // Reset in the middle of WRITE
        resetA = 1'b1;
        nextCycle();
        resetA = 1'b0;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("t5_rst_we", 32'(ifA.we), 32'd0);
        checkOutput("t5_rst_armed", 32'(ifA.armed), 32'd0);
        checkOutput("t5_rst_triggered", 32'(ifA.triggered), 32'd0);
        checkOutput("t5_rst_done", 32'(ifA.done), 32'd0);
        checkOutput("t5_rst_trig_chan", 32'(ifA.trig_chan), 32'd0);

        // Auto-armed instance, all channels on either edge
        resetB = 1'b0;
        #1;
        checkOutput("t6_prime_armed", 32'(ifB.armed), 32'd1);
        nextCycle();
        ifB.data = 4'b1000;
        #1;
        checkOutput("t6_auto_we", 32'(ifB.we), 32'd1);
        nextCycle();
        checkOutput("t6_auto_trig_chan", 32'(ifB.trig_chan), 32'h8);
        checkOutput("t6_auto_triggered", 32'(ifB.triggered), 32'd1);

        // Auto-armed instance with every channel ignored never triggers
        ifB.edge_sel = 8'h00;
        resetB = 1'b1;
        nextCycle();
        resetB = 1'b0;
        ifB.data = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            nextCycle();
            ifB.data = ~ifB.data;
            #1;
            checkOutput($sformatf("t7_none_we_%0d", k), 32'(ifB.we), 32'd0);
        end
        nextCycle();
        checkOutput("t7_none_triggered", 32'(ifB.triggered), 32'd0);
        checkOutput("t7_none_armed", 32'(ifB.armed), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
